// File: rtl/cnn_window_stream.sv
// cnn_window_stream: multi-channel K x K sliding-window generator with on-the-fly
// zero padding and stride, fed by a raster pixel stream over valid/ready.
module cnn_window_stream #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CH     = 4,
  parameter int unsigned K_MAX  = 3,
  parameter int unsigned W_MAX  = 64,
  parameter int unsigned H_MAX  = 64
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [$clog2(W_MAX):0]               cfg_width,
  input  logic [$clog2(H_MAX):0]               cfg_height,
  input  logic [$clog2(K_MAX):0]               cfg_kernel,
  input  logic [2:0]                           cfg_stride,
  input  logic [$clog2(K_MAX):0]               cfg_pad,
  output logic                                 cfg_err,
  input  logic                                 in_valid,
  input  logic [CH*DATA_W-1:0]                 in_data,
  output logic                                 in_ready,
  output logic                                 out_valid,
  output logic [K_MAX*K_MAX*CH*DATA_W-1:0]     out_data,
  input  logic                                 out_ready,
  output logic                                 busy,
  output logic                                 done
);
  localparam int unsigned PIX_W   = CH * DATA_W;
  localparam int unsigned OUT_W   = K_MAX * K_MAX * PIX_W;
  localparam int unsigned KW      = $clog2(K_MAX) + 1;
  localparam int unsigned DIM_MAX = ((W_MAX > H_MAX) ? W_MAX : H_MAX) + 2 * K_MAX;
  localparam int unsigned CW      = $clog2(DIM_MAX) + 1;
  localparam int unsigned LD      = W_MAX + 2 * (K_MAX - 1);
  localparam int unsigned LAW     = $clog2(LD);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [2:0]      s_q, s_d;
  logic [CW-1:0]   pad_q, pad_d, wp_q, wp_d, hp_q, hp_d;
  logic [CW-1:0]   w_end_q, w_end_d, h_end_q, h_end_d;
  logic [CW-1:0]   pr_q, pr_d, pc_q, pc_d;
  logic [2:0]      rph_q, rph_d, cph_q, cph_d;
  logic            scan_done_q, scan_done_d;
  logic            out_valid_q, out_valid_d;
  logic            cfg_err_q, cfg_err_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;

  logic [PIX_W-1:0] win_q [K_MAX][K_MAX];
  logic [PIX_W-1:0] win_d [K_MAX][K_MAX];
  logic [PIX_W-1:0] lm_q  [K_MAX-1][LD];
  logic [PIX_W-1:0] new_col [K_MAX];

  logic [PIX_W-1:0] pix;
  logic [LAW-1:0]   lm_idx;
  logic [CW-1:0]    kq1;
  logic             run, stalled, pad_pos, emit, advance, cfg_ok;
  int unsigned      k_int;

  always_comb begin
    int unsigned kk, ss, pp, ww, hh;
    kk = 32'(cfg_kernel);
    ss = 32'(cfg_stride);
    pp = 32'(cfg_pad);
    ww = 32'(cfg_width);
    hh = 32'(cfg_height);
    cfg_ok = (kk >= 1) && (kk <= K_MAX) && (ss != 0) && (pp < kk) &&
             (ww >= 1) && (ww <= W_MAX) && (hh >= 1) && (hh <= H_MAX) &&
             (kk <= ww + 2 * pp) && (kk <= hh + 2 * pp);
  end

  assign run      = (state_q == S_RUN);
  assign k_int    = 32'(k_q);
  assign kq1      = CW'(k_q) - CW'(1);
  assign lm_idx   = pc_q[LAW-1:0];
  assign pad_pos  = (pr_q < pad_q) | (pr_q >= h_end_q) | (pc_q < pad_q) | (pc_q >= w_end_q);
  assign stalled  = out_valid_q & ~out_ready;
  // Phase counters stand in for (pos-K+1)%S; they only run once pos reaches K-1.
  assign emit     = (pr_q >= kq1) & (pc_q >= kq1) & (rph_q == '0) & (cph_q == '0);
  assign advance  = run & ~scan_done_q & ~stalled & (pad_pos | in_valid);
  assign in_ready = run & ~scan_done_q & ~pad_pos & ~stalled;
  assign pix      = pad_pos ? '0 : in_data;

  // Live window sits in rows/cols 0..K-1; the newest column enters at col K-1.
  always_comb begin
    for (int unsigned r = 0; r < K_MAX; r++) begin
      new_col[r] = '0;
      if (r + 1 == k_int) begin
        new_col[r] = pix;
      end else begin
        for (int unsigned j = 0; j < K_MAX - 1; j++) begin
          if (j + r + 2 == k_int) new_col[r] = lm_q[j][lm_idx];
        end
      end
    end
    win_d = win_q;
    if (advance) begin
      for (int unsigned r = 0; r < K_MAX; r++) begin
        for (int unsigned c = 0; c < K_MAX; c++) begin
          if (r >= k_int)          win_d[r][c] = '0;
          else if (c + 1 < k_int)  win_d[r][c] = win_q[r][(c + 1) % K_MAX];
          else if (c + 1 == k_int) win_d[r][c] = new_col[r];
          else                     win_d[r][c] = '0;
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    s_d         = s_q;
    pad_d       = pad_q;
    wp_d        = wp_q;
    hp_d        = hp_q;
    w_end_d     = w_end_q;
    h_end_d     = h_end_q;
    pr_d        = pr_q;
    pc_d        = pc_q;
    rph_d       = rph_q;
    cph_d       = cph_q;
    scan_done_d = scan_done_q;
    cfg_err_d   = 1'b0;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    unique case (state_q)
      S_IDLE: begin
        out_data_d = '0;
        if (start) begin
          if (cfg_ok) begin
            state_d     = S_RUN;
            k_d         = cfg_kernel;
            s_d         = cfg_stride;
            pad_d       = CW'(cfg_pad);
            wp_d        = CW'(cfg_width) + CW'(cfg_pad) + CW'(cfg_pad);
            hp_d        = CW'(cfg_height) + CW'(cfg_pad) + CW'(cfg_pad);
            w_end_d     = CW'(cfg_width) + CW'(cfg_pad);
            h_end_d     = CW'(cfg_height) + CW'(cfg_pad);
            pr_d        = '0;
            pc_d        = '0;
            rph_d       = '0;
            cph_d       = '0;
            scan_done_d = 1'b0;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        out_valid_d = stalled | (advance & emit);
        if (advance) begin
          if (pc_q == wp_q - CW'(1)) begin
            pc_d  = '0;
            cph_d = '0;
            if (pr_q == hp_q - CW'(1)) begin
              scan_done_d = 1'b1;
            end else begin
              pr_d = pr_q + CW'(1);
              if (pr_q >= kq1) rph_d = (rph_q == s_q - 3'd1) ? '0 : rph_q + 3'd1;
            end
          end else begin
            pc_d = pc_q + CW'(1);
            if (pc_q >= kq1) cph_d = (cph_q == s_q - 3'd1) ? '0 : cph_q + 3'd1;
          end
          if (emit) begin
            for (int unsigned r = 0; r < K_MAX; r++) begin
              for (int unsigned c = 0; c < K_MAX; c++) begin
                out_data_d[(r * K_MAX + c) * PIX_W +: PIX_W] = win_d[r][c];
              end
            end
          end
        end
        if (scan_done_q && !out_valid_q) state_d = S_DONE;
      end
      S_DONE: begin
        out_data_d = '0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      s_q         <= '0;
      pad_q       <= '0;
      wp_q        <= '0;
      hp_q        <= '0;
      w_end_q     <= '0;
      h_end_q     <= '0;
      pr_q        <= '0;
      pc_q        <= '0;
      rph_q       <= '0;
      cph_q       <= '0;
      scan_done_q <= 1'b0;
      out_valid_q <= 1'b0;
      cfg_err_q   <= 1'b0;
      out_data_q  <= '0;
      win_q       <= '{default: '0};
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      s_q         <= s_d;
      pad_q       <= pad_d;
      wp_q        <= wp_d;
      hp_q        <= hp_d;
      w_end_q     <= w_end_d;
      h_end_q     <= h_end_d;
      pr_q        <= pr_d;
      pc_q        <= pc_d;
      rph_q       <= rph_d;
      cph_q       <= cph_d;
      scan_done_q <= scan_done_d;
      out_valid_q <= out_valid_d;
      cfg_err_q   <= cfg_err_d;
      out_data_q  <= out_data_d;
      win_q       <= win_d;
    end
  end

  // Line memory holds no reset; stale rows are never emitted.
  always_ff @(posedge clk) begin
    if (advance) begin
      for (int unsigned j = K_MAX - 2; j > 0; j--) begin
        lm_q[j][lm_idx] <= lm_q[j-1][lm_idx];
      end
      lm_q[0][lm_idx] <= pix;
    end
  end

  assign cfg_err   = cfg_err_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = run;
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_cnn_window_stream.sv
// Self-checking bench for cnn_window_stream: table of frame configs plus random
// frames, compared against a direct padded-frame window model.
module tb_cnn_window_stream;
  localparam int DATA_W = 8;
  localparam int CH     = 4;
  localparam int K_MAX  = 3;
  localparam int W_MAX  = 64;
  localparam int H_MAX  = 64;
  localparam int PIX_W  = CH * DATA_W;
  localparam int OUT_W  = K_MAX * K_MAX * PIX_W;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 start = 1'b0;
  logic [6:0]           cfg_width = '0;
  logic [6:0]           cfg_height = '0;
  logic [2:0]           cfg_kernel = '0;
  logic [2:0]           cfg_stride = '0;
  logic [2:0]           cfg_pad = '0;
  logic                 cfg_err;
  logic                 in_valid = 1'b0;
  logic [PIX_W-1:0]     in_data = '0;
  logic                 in_ready;
  logic                 out_valid;
  logic [OUT_W-1:0]     out_data;
  logic                 out_ready = 1'b0;
  logic                 busy;
  logic                 done;

  cnn_window_stream #(
    .DATA_W(DATA_W), .CH(CH), .K_MAX(K_MAX), .W_MAX(W_MAX), .H_MAX(H_MAX)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_kernel(cfg_kernel),
    .cfg_stride(cfg_stride), .cfg_pad(cfg_pad), .cfg_err(cfg_err),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk_w(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_v(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  typedef struct {
    int w, h, k, s, p;
    int pat;
    bit stall;
    int vprob, rprob;
    int exp_cnt, exp_lead;
  } frame_t;

  task automatic run_frame(input frame_t f, input string tag);
    logic [PIX_W-1:0] pix [$];
    logic [OUT_W-1:0] expq [$];
    logic [OUT_W-1:0] v, hold;
    logic [7:0] b;
    int wo, ho, y, x, in_idx, got, lead, cyc, bound, stall_left;
    bit fin, stall_used;
    for (int n = 0; n < f.w * f.h; n++) begin
      b = 8'(n);
      if (f.pat == 0) pix.push_back({CH{b}});
      else            pix.push_back(PIX_W'($urandom));
    end
    wo = (f.w + 2 * f.p - f.k) / f.s + 1;
    ho = (f.h + 2 * f.p - f.k) / f.s + 1;
    for (int oy = 0; oy < ho; oy++) begin
      for (int ox = 0; ox < wo; ox++) begin
        v = '0;
        for (int r = 0; r < f.k; r++) begin
          for (int c = 0; c < f.k; c++) begin
            y = oy * f.s + r - f.p;
            x = ox * f.s + c - f.p;
            if (y >= 0 && y < f.h && x >= 0 && x < f.w)
              v[(r * K_MAX + c) * PIX_W +: PIX_W] = pix[y * f.w + x];
          end
        end
        expq.push_back(v);
      end
    end

    @(negedge clk);
    cfg_width  = 7'(f.w);
    cfg_height = 7'(f.h);
    cfg_kernel = 3'(f.k);
    cfg_stride = 3'(f.s);
    cfg_pad    = 3'(f.p);
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    cfg_width  = 7'($urandom);
    cfg_height = 7'($urandom);
    cfg_kernel = 3'($urandom);
    cfg_stride = 3'($urandom);
    cfg_pad    = 3'($urandom);

    in_idx = 0; got = 0; lead = -1; cyc = 0; stall_left = 0;
    fin = 1'b0; stall_used = 1'b0; hold = '0;
    bound = 40 * (f.w + 2 * f.p) * (f.h + 2 * f.p) + 200;
    while (!fin && cyc < bound) begin
      in_valid  = (in_idx < f.w * f.h) && ($urandom_range(99) < f.vprob);
      in_data   = in_valid ? pix[in_idx] : PIX_W'($urandom);
      out_ready = (stall_left > 0) ? 1'b0 : ($urandom_range(99) < f.rprob);
      #1;
      if (stall_left > 0) begin
        chk_v({tag, "_stall_valid"}, int'(out_valid), 1);
        chk_w({tag, "_stall_data"}, out_data, hold);
        chk_v({tag, "_stall_in_ready"}, int'(in_ready), 0);
        stall_left--;
      end else if (f.stall && !stall_used && out_valid) begin
        stall_used = 1'b1;
        stall_left = 9;
        hold       = out_data;
        out_ready  = 1'b0;
        #1;
        chk_v({tag, "_stall_in_ready"}, int'(in_ready), 0);
      end
      if (lead < 0 && in_ready) lead = cyc;
      if (in_valid && in_ready) in_idx++;
      if (out_valid && out_ready) begin
        if (got < expq.size()) chk_w($sformatf("%s_win%0d", tag, got), out_data, expq[got]);
        got++;
      end
      if (done) fin = 1'b1;
      cyc++;
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk_v({tag, "_done_seen"}, int'(fin), 1);
    chk_v({tag, "_win_count"}, got, expq.size());
    chk_v({tag, "_beats"}, in_idx, f.w * f.h);
    if (f.exp_cnt >= 0)  chk_v({tag, "_win_count_plan"}, got, f.exp_cnt);
    if (f.exp_lead >= 0) chk_v({tag, "_pad_lead"}, lead, f.exp_lead);
    if (f.stall)         chk_v({tag, "_stall_hit"}, int'(stall_used), 1);
    #1;
    chk_v({tag, "_done_pulse"}, int'(done), 0);
    chk_v({tag, "_idle_busy"}, int'(busy), 0);
    chk_w({tag, "_idle_data"}, out_data, '0);
  endtask

  initial begin
    #800_000;
    $display("FAIL watchdog: time limit reached, %0d/%0d so far", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    frame_t tbl [8];
    frame_t rf;
    tbl[0] = '{w:4,  h:4, k:3, s:1, p:0, pat:0, stall:0, vprob:100, rprob:100, exp_cnt:4,  exp_lead:0};
    tbl[1] = '{w:4,  h:4, k:3, s:1, p:1, pat:0, stall:0, vprob:100, rprob:100, exp_cnt:16, exp_lead:7};
    tbl[2] = '{w:5,  h:5, k:3, s:2, p:0, pat:0, stall:0, vprob:70,  rprob:80,  exp_cnt:4,  exp_lead:-1};
    tbl[3] = '{w:4,  h:4, k:3, s:1, p:0, pat:0, stall:1, vprob:100, rprob:100, exp_cnt:4,  exp_lead:-1};
    tbl[4] = '{w:4,  h:4, k:1, s:1, p:0, pat:0, stall:0, vprob:100, rprob:100, exp_cnt:16, exp_lead:-1};
    tbl[5] = '{w:64, h:3, k:3, s:3, p:2, pat:1, stall:0, vprob:90,  rprob:90,  exp_cnt:44, exp_lead:-1};
    tbl[6] = '{w:1,  h:1, k:3, s:1, p:2, pat:1, stall:1, vprob:50,  rprob:50,  exp_cnt:9,  exp_lead:-1};
    tbl[7] = '{w:2,  h:7, k:2, s:7, p:1, pat:1, stall:0, vprob:60,  rprob:60,  exp_cnt:2,  exp_lead:-1};

    repeat (3) @(negedge clk);
    #1;
    chk_v("rst_out_valid", int'(out_valid), 0);
    chk_v("rst_in_ready", int'(in_ready), 0);
    chk_v("rst_busy", int'(busy), 0);
    chk_v("rst_done", int'(done), 0);
    chk_v("rst_cfg_err", int'(cfg_err), 0);
    chk_w("rst_out_data", out_data, '0);
    rst = 1'b1;

    for (int i = 0; i < 8; i++) run_frame(tbl[i], $sformatf("tbl%0d", i));

    // Illegal config: pad not below kernel.
    @(negedge clk);
    cfg_width = 7'd4; cfg_height = 7'd4; cfg_kernel = 3'd3; cfg_stride = 3'd1; cfg_pad = 3'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk_v("err_pulse", int'(cfg_err), 1);
    chk_v("err_busy", int'(busy), 0);
    @(negedge clk);
    #1;
    chk_v("err_clear", int'(cfg_err), 0);
    chk_v("err_busy2", int'(busy), 0);

    // Legal frame interrupted by reset while a window is held.
    @(negedge clk);
    cfg_pad = 3'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1;
    in_data = 32'h0101_0101;
    out_ready = 1'b0;
    repeat (14) @(negedge clk);
    #1;
    chk_v("midrst_pre_valid", int'(out_valid), 1);
    chk_v("midrst_pre_busy", int'(busy), 1);
    #2;
    rst = 1'b0;
    #1;
    chk_v("midrst_out_valid", int'(out_valid), 0);
    chk_v("midrst_in_ready", int'(in_ready), 0);
    chk_v("midrst_busy", int'(busy), 0);
    chk_w("midrst_out_data", out_data, '0);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    run_frame(tbl[1], "post_rst");

    for (int i = 0; i < 6; i++) begin
      rf.k = $urandom_range(1, 3);
      rf.p = $urandom_range(0, rf.k - 1);
      rf.s = $urandom_range(1, 7);
      rf.w = $urandom_range(1, 10);
      rf.h = $urandom_range(1, 10);
      if (rf.k > rf.w + 2 * rf.p) rf.w = rf.k;
      if (rf.k > rf.h + 2 * rf.p) rf.h = rf.k;
      rf.pat = 1;
      rf.stall = 1'($urandom);
      rf.vprob = $urandom_range(40, 100);
      rf.rprob = $urandom_range(40, 100);
      rf.exp_cnt = -1;
      rf.exp_lead = -1;
      run_frame(rf, $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
